// File: rtl/multicycle_controller.sv
// Main controller for a multicycle MIPS datapath: Moore sequencing FSM plus ALU decoder.
// Supports lw, sw, R-type add/sub/and/or/slt, beq, addi and j.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t     state_q, state_d;
    logic [1:0] aluop;
    logic       pcwrite, branch;
    logic       irwrite_raw, regwrite_raw, memwrite_raw;
    logic       state_valid;

    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d      = FETCH;
        aluop        = 2'b00;
        pcwrite      = 1'b0;
        branch       = 1'b0;
        irwrite_raw  = 1'b0;
        regwrite_raw = 1'b0;
        memwrite_raw = 1'b0;
        iord         = 1'b0;
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        pcsrc        = 2'b00;
        illegal      = 1'b0;
        state_valid  = 1'b1;
        case (state_q)
            FETCH: begin
                alusrcb     = 2'b01;
                irwrite_raw = 1'b1;
                pcwrite     = 1'b1;
                state_d     = DECODE;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default: begin
                        illegal = 1'b1;
                        state_d = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                iord    = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                memtoreg     = 1'b1;
                regwrite_raw = 1'b1;
            end
            MEMWR: begin
                iord         = 1'b1;
                memwrite_raw = 1'b1;
            end
            EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                state_d = ALUWB;
            end
            ALUWB: begin
                regdst       = 1'b1;
                regwrite_raw = 1'b1;
            end
            BRANCH: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = ADDIWB;
            end
            ADDIWB: regwrite_raw = 1'b1;
            JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: state_valid = 1'b0;
        endcase
    end

    // Unused encodings drive every output low, including the ALU function.
    always_comb begin
        alucontrol = 3'b000;
        if (state_valid) begin
            case (aluop)
                2'b00: alucontrol = 3'b010;
                2'b01: alucontrol = 3'b110;
                default: begin
                    case (funct)
                        6'b100010: alucontrol = 3'b110;
                        6'b100100: alucontrol = 3'b000;
                        6'b100101: alucontrol = 3'b001;
                        6'b101010: alucontrol = 3'b111;
                        default:   alucontrol = 3'b010;
                    endcase
                end
            endcase
        end
    end

    // Write strobes are gated by reset so an abandoned instruction commits nothing.
    assign pcen     = (pcwrite | (branch & zero)) & ~reset;
    assign irwrite  = irwrite_raw  & ~reset;
    assign regwrite = regwrite_raw & ~reset;
    assign memwrite = memwrite_raw & ~reset;
    assign state    = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed scenarios then random
// instruction streams (with random mid-instruction resets) against an instruction-level model.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero;
    logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       illegal;
    logic [3:0] state;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    typedef int path_t[$];

    // Per-state controls: iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,pcwrite,branch
    localparam logic [12:0] CTRL [12] = '{
        13'b0_0_1_0_0_0_0_01_00_1_0,  // 0  fetch
        13'b0_0_0_0_0_0_0_11_00_0_0,  // 1  decode
        13'b0_0_0_0_0_0_1_10_00_0_0,  // 2  memadr
        13'b1_0_0_0_0_0_0_00_00_0_0,  // 3  memrd
        13'b0_0_0_0_1_1_0_00_00_0_0,  // 4  memwb
        13'b1_1_0_0_0_0_0_00_00_0_0,  // 5  memwr
        13'b0_0_0_0_0_0_1_00_00_0_0,  // 6  execute
        13'b0_0_0_1_0_1_0_00_00_0_0,  // 7  aluwb
        13'b0_0_0_0_0_0_1_00_01_0_1,  // 8  branch
        13'b0_0_0_0_0_0_1_10_00_0_0,  // 9  addiex
        13'b0_0_0_0_0_1_0_00_00_0_0,  // 10 addiwb
        13'b0_0_0_0_0_0_0_00_10_1_0   // 11 jump
    };

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pcen(pcen), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .alucontrol(alucontrol), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Whole-instruction state walk, FETCH first, the return to FETCH excluded.
    function automatic path_t path_of(input logic [5:0] o);
        case (o)
            6'b100011: return '{0, 1, 2, 3, 4};
            6'b101011: return '{0, 1, 2, 5};
            6'b000000: return '{0, 1, 6, 7};
            6'b001000: return '{0, 1, 9, 10};
            6'b000100: return '{0, 1, 8};
            6'b000010: return '{0, 1, 11};
            default:   return '{0, 1};
        endcase
    endfunction

    function automatic logic [2:0] rtype_alu(input logic [5:0] f);
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    task automatic check_cycle(input int s, input logic rst, input logic is_illegal);
        logic [12:0] c;
        logic        e_pcen;
        logic [2:0]  e_alu;
        c      = CTRL[s];
        e_pcen = (c[1] | (c[0] & zero)) & ~rst;
        e_alu  = (s == 6) ? rtype_alu(funct) : (s == 8) ? 3'b110 : 3'b010;
        check("state", 32'(state), 32'(s));
        check("strobes", {28'd0, pcen, irwrite, regwrite, memwrite},
              {28'd0, e_pcen, c[10] & ~rst, c[7] & ~rst, c[11] & ~rst});
        check("muxsel", {23'd0, iord, regdst, memtoreg, alusrca, alusrcb, pcsrc},
              {23'd0, c[12], c[9], c[8], c[6], c[5:4], c[3:2]});
        check("alucontrol", 32'(alucontrol), 32'(e_alu));
        check("illegal", 32'(illegal), 32'(is_illegal));
    endtask

    // Runs one instruction; abort_at >= 0 asserts reset in that cycle of the walk.
    // rand_zero=0 holds zero at zval for the whole instruction.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic zval,
                             input bit rand_zero, input int abort_at);
        path_t p;
        p = path_of(o);
        for (int i = 0; i < p.size(); i++) begin
            op    = o;
            funct = f;
            zero  = rand_zero ? 1'($urandom_range(0, 1)) : zval;
            reset = (i == abort_at);
            #3;
            check_cycle(p[i], reset, (p[i] == 1) && (p.size() == 2));
            @(posedge clk);
            #1;
            if (i == abort_at) begin
                reset = 1'b0;
                break;
            end
        end
    endtask

    localparam logic [5:0] OPS [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b001000, 6'b000100, 6'b000010};
    localparam logic [5:0] FNS [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    initial begin
        logic [5:0] o, f;
        int         ab;
        reset = 1'b1;
        op    = 6'b100011;
        funct = '0;
        zero  = 1'b1;
        @(posedge clk);
        #4;
        check_cycle(0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_instr(6'b100011, 6'b000000, 1'b0, 1'b0, -1);   // lw
        run_instr(6'b101011, 6'b000000, 1'b0, 1'b0, -1);   // sw
        run_instr(6'b000000, 6'b100010, 1'b0, 1'b0, -1);   // sub
        run_instr(6'b000000, 6'b101010, 1'b0, 1'b0, -1);   // slt
        run_instr(6'b000100, 6'b000000, 1'b1, 1'b0, -1);   // beq taken
        run_instr(6'b000100, 6'b000000, 1'b0, 1'b0, -1);   // beq not taken
        run_instr(6'b000010, 6'b000000, 1'b0, 1'b0, -1);   // j
        run_instr(6'b111111, 6'b000000, 1'b0, 1'b0, -1);   // illegal
        run_instr(6'b100011, 6'b000000, 1'b0, 1'b0, 4);    // reset in MEMWB
        run_instr(6'b001000, 6'b000000, 1'b0, 1'b0, -1);   // addi

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 6) == 0) o = 6'($urandom());
            else                           o = OPS[$urandom_range(0, 5)];
            if ($urandom_range(0, 4) == 0) f = 6'($urandom());
            else                           f = FNS[$urandom_range(0, 4)];
            ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_instr(o, f, 1'b0, 1'b1, ab);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore FSM plus ALU decoder that sequences the shared MIPS multicycle datapath: one ALU, one unified memory, PC, IR, regfile.
- Issues per-state mux selects and write enables so one instruction completes over 3–5 cycles.
- Sits beside the datapath; consumes op/funct from the IR and the ALU zero flag.

Parameters:
- none (ISA subset fixed: lw, sw, R-type add/sub/and/or/slt, beq, addi, j)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; forces state to FETCH at next edge
- op  input  6  instr[31:26] from IR
- funct  input  6  instr[5:0] from IR
- zero  input  1  ALU zero flag (current cycle)
- pcen  output  1  PC register enable = pcwrite | (branch & zero)
- iord  output  1  memory address select: 0=PC, 1=ALUOut
- memwrite  output  1  memory write strobe
- irwrite  output  1  IR load enable
- regdst  output  1  write-register select: 0=rt, 1=rd
- memtoreg  output  1  writeback select: 0=ALUOut, 1=Data register
- regwrite  output  1  regfile write enable
- alusrca  output  1  ALU A: 0=PC, 1=register A
- alusrcb  output  2  ALU B: 00=reg B, 01=constant 4, 10=signimm, 11=signimm<<2
- pcsrc  output  2  next PC: 00=ALU result, 01=ALUOut, 10=jump target
- alucontrol  output  3  ALU function
- illegal  output  1  one-cycle pulse in DECODE for an unsupported opcode
- state  output  4  current state encoding (debug/verification)

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
- Codes 12–15 are unreachable. If entered, the FSM goes to FETCH on the next edge with all outputs 0.
- Transitions:
  - FETCH -> DECODE.
  - DECODE branches on op: lw(100011) or sw(101011) -> MEMADR; R-type(000000) -> EXECUTE; beq(000100) -> BRANCH; addi(001000) -> ADDIEX; j(000010) -> JUMP; any other op -> FETCH with illegal=1 for that cycle.
  - MEMADR -> MEMRD if op=lw, else MEMWR.
  - MEMRD -> MEMWB.
  - EXECUTE -> ALUWB.
  - ADDIEX -> ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP -> FETCH.
- Outputs per state (all unlisted outputs are 0; aluop is internal):
  - FETCH: alusrcb=01, aluop=00, irwrite=1, pcwrite=1.
  - DECODE: alusrcb=11, aluop=00.
  - MEMADR: alusrca=1, alusrcb=10, aluop=00.
  - MEMRD: iord=1.
  - MEMWB: memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1.
  - EXECUTE: alusrca=1, alusrcb=00, aluop=10.
  - ALUWB: regdst=1, regwrite=1.
  - BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1.
  - ADDIEX: alusrca=1, alusrcb=10, aluop=00.
  - ADDIWB: regwrite=1.
  - JUMP: pcsrc=10, pcwrite=1.
- ALU decoder (combinational):
  - aluop=00 -> 010 (add); aluop=01 -> 110 (sub).
  - aluop=10 decodes funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, other funct -> 010.
- Cycle counts, FETCH to return to FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Reset:
  - While reset=1, pcen, irwrite, regwrite and memwrite are forced 0 combinationally.
  - After the first reset edge: state=0 and illegal=0. Mux-select outputs show FETCH values.
  - Reset mid-instruction abandons the instruction; no write strobe fires in the reset cycles.
- pcen in BRANCH follows zero in the same cycle; there is no registered delay.
- op and funct are sampled only from the IR. The FSM assumes the IR is stable from DECODE onward (irwrite=1 only in FETCH).

Test Plan:
- Reset held 2 cycles, then released with op=100011 (lw) -> state sequence 0,1,2,3,4,0. regwrite=1 and memtoreg=1 only in state 4. pcen=1 only in the first FETCH cycle after release.
- sw op=101011 -> states 0,1,2,5,0. memwrite=1 and iord=1 only in state 5. regwrite stays 0 throughout.
- R-type op=000000 with funct 100010, then 101010 -> alucontrol=110, then 111, in EXECUTE. ALUWB shows regdst=1, regwrite=1.
- beq with zero=1, then beq with zero=0 -> BRANCH shows pcsrc=01 in both cases. pcen=1 for the zero=1 case, pcen=0 for the zero=0 case.
- op=000010 (j) -> states 0,1,11,0 with pcsrc=10, pcen=1 in JUMP. op=111111 -> illegal=1 in DECODE, next state 0.
- Reset asserted in state 4 (MEMWB) -> regwrite=0 in that cycle, state=0 after the edge. A subsequent addi runs 0,1,9,10,0.
